// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared PDP-8 constants: accumulator width, rotater FSM states, rotate directions
package pdp8_pkg;
  localparam int AC_WIDTH = 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    DIR_LEFT,
    DIR_RIGHT,
    DIR_SWAP
  } dir_t;
endpackage

// File: rtl/rotater_seq_if.sv
// rtl/rotater_seq_if.sv - request/result bundle between the OPR decoder, link register, AC and the rotater
interface rotater_seq_if #(
  parameter int AC_WIDTH = pdp8_pkg::AC_WIDTH
);
  logic                START;
  logic                RAR;
  logic                RAL;
  logic                BSW;
  logic [AC_WIDTH-1:0] AC_IN;
  logic                LINK_IN;
  logic [AC_WIDTH-1:0] AC_OUT;
  logic                LINK_OUT;
  logic                LINK_SET;
  logic                AC_LOAD;
  logic                BUSY;

  modport master (
    output START, RAR, RAL, BSW, AC_IN, LINK_IN,
    input  AC_OUT, LINK_OUT, LINK_SET, AC_LOAD, BUSY
  );

  modport slave (
    input  START, RAR, RAL, BSW, AC_IN, LINK_IN,
    output AC_OUT, LINK_OUT, LINK_SET, AC_LOAD, BUSY
  );
endinterface

// File: rtl/rotater_seq_rot_step.sv
// rtl/rotater_seq_rot_step.sv - one combinational rotate step on the {L,AC} word
module rot_step
  import pdp8_pkg::*;
#(
  parameter int AC_WIDTH = pdp8_pkg::AC_WIDTH
) (
  input  dir_t              dir,
  input  logic [AC_WIDTH:0] word,
  output logic [AC_WIDTH:0] next
);
  localparam int HALF = AC_WIDTH / 2;

  // word[AC_WIDTH] is the link; left/right rotate through it, swap leaves it alone
  always_comb begin
    next = word;
    case (dir)
      DIR_LEFT:  next = {word[AC_WIDTH-1:0], word[AC_WIDTH]};
      DIR_RIGHT: next = {word[0], word[AC_WIDTH:1]};
      DIR_SWAP:  next = {word[AC_WIDTH], word[HALF-1:0], word[AC_WIDTH-1:HALF]};
      default:   next = word;
    endcase
  end
endmodule

// File: rtl/rotater_seq.sv
// rtl/rotater_seq.sv - sequential OPR group 1 rotater (RAR/RAL/RTR/RTL/BSW), one step per clock
// ROTATER_BSW_EN: when defined, BSW alone performs a half-word swap; otherwise it passes through.
module rotater_seq
  import pdp8_pkg::*;
#(
  parameter int AC_WIDTH = pdp8_pkg::AC_WIDTH
) (
  input  logic        clk,
  input  logic        reset_n,
  rotater_seq_if.slave bus
);
  logic [1:0]        state;
  logic [1:0]        steps;
  dir_t              dir;
  logic [AC_WIDTH:0] work;
  logic [AC_WIDTH:0] work_next;
  logic [1:0]        dec_steps;
  dir_t              dec_dir;

  // RAL and RAR together cancel; BSW doubles a single rotate
  always_comb begin
    dec_steps = 2'd0;
    dec_dir   = DIR_LEFT;
    if (bus.RAL && !bus.RAR) begin
      dec_steps = bus.BSW ? 2'd2 : 2'd1;
      dec_dir   = DIR_LEFT;
    end else if (bus.RAR && !bus.RAL) begin
      dec_steps = bus.BSW ? 2'd2 : 2'd1;
      dec_dir   = DIR_RIGHT;
    end else if (bus.BSW && !bus.RAL && !bus.RAR) begin
`ifdef ROTATER_BSW_EN
      dec_steps = 2'd1;
      dec_dir   = DIR_SWAP;
`else
      dec_steps = 2'd0;
      dec_dir   = DIR_LEFT;
`endif
    end
  end

  rot_step #(.AC_WIDTH(AC_WIDTH)) u_step (
    .dir  (dir),
    .word (work),
    .next (work_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      steps <= 2'd0;
      dir   <= DIR_LEFT;
      work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            work  <= {bus.LINK_IN, bus.AC_IN};
            steps <= dec_steps;
            dir   <= dec_dir;
            state <= (dec_steps != 2'd0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          work  <= work_next;
          steps <= steps - 2'd1;
          if (steps == 2'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.AC_OUT   = work[AC_WIDTH-1:0];
  assign bus.LINK_OUT = work[AC_WIDTH];
  assign bus.LINK_SET = (state == DONE);
  assign bus.AC_LOAD  = (state == DONE);
  assign bus.BUSY     = (state == SHIFT) || (state == DONE);
endmodule

// File: tb/tb_rotater_seq.sv
// tb/tb_rotater_seq.sv - self-checking bench for rotater_seq against a 13-bit rotate reference model
module tb_rotater_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rotater_seq_if bus ();

  rotater_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // reference: rotate the 13-bit {L,AC} value n places, or swap AC halves
  function automatic void model(input logic l, input logic [11:0] ac,
                                input logic ral, input logic rar, input logic bsw,
                                output logic l_e, output logic [11:0] ac_e, output int n_e);
    int v;
    v   = int'({l, ac});
    n_e = 0;
    if (ral && !rar) begin
      n_e = bsw ? 2 : 1;
      v   = ((v << n_e) | (v >> (13 - n_e))) & 'h1fff;
    end else if (rar && !ral) begin
      n_e = bsw ? 2 : 1;
      v   = ((v >> n_e) | (v << (13 - n_e))) & 'h1fff;
    end else if (bsw && !ral && !rar) begin
`ifdef ROTATER_BSW_EN
      n_e = 1;
      v   = (int'(l) << 12) | ((int'(ac) % 64) * 64) | (int'(ac) / 64);
`endif
    end
    l_e  = v[12];
    ac_e = v[11:0];
  endfunction

  // drives one request, then observes 6 cycles; optionally re-pulses START at cycle restart_at
  task automatic run_op(input logic l, input logic [11:0] ac, input logic ral, input logic rar,
                        input logic bsw, input int restart_at,
                        output int lat, output int strobes, output int busy, output int split,
                        output logic l_o, output logic [11:0] ac_o);
    @(negedge clk);
    bus.LINK_IN = l; bus.AC_IN = ac; bus.RAL = ral; bus.RAR = rar; bus.BSW = bsw;
    bus.START = 1'b1;
    lat = -1; strobes = 0; busy = 0; split = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.START   = (k == restart_at);
      bus.AC_IN   = 12'($urandom);
      bus.LINK_IN = 1'($urandom);
      bus.RAL     = 1'($urandom);
      bus.RAR     = 1'($urandom);
      bus.BSW     = 1'($urandom);
      if (bus.BUSY) busy++;
      if (bus.LINK_SET !== bus.AC_LOAD) split++;
      if (bus.LINK_SET) begin strobes++; lat = k; end
    end
    bus.START = 1'b0;
    l_o  = bus.LINK_OUT;
    ac_o = bus.AC_OUT;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.START = 0; bus.RAL = 0; bus.RAR = 0; bus.BSW = 0; bus.AC_IN = '0; bus.LINK_IN = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.AC_OUT, bus.LINK_OUT, bus.LINK_SET, bus.AC_LOAD, bus.BUSY} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0000",
               {bus.AC_OUT, bus.LINK_OUT, bus.LINK_SET, bus.AC_LOAD, bus.BUSY});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [11:0] t_ac [5] = '{12'o4000, 12'o0001, 12'o3000, 12'o0077, 12'o1234};
    logic        t_l  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  t_op [5] = '{3'b010, 3'b101, 3'b011, 3'b001, 3'b110}; // {RAR,RAL,BSW}
    logic [11:0] e_ac [5] = '{12'o0000, 12'o6000, 12'o4000,
`ifdef ROTATER_BSW_EN
                              12'o7700,
`else
                              12'o0077,
`endif
                              12'o1234};
    logic        e_l  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int          e_n  [5] = '{1, 2, 2,
`ifdef ROTATER_BSW_EN
                              1,
`else
                              0,
`endif
                              0};
    int lat, strobes, busy, split;
    logic l_o;
    logic [11:0] ac_o;
    for (int i = 0; i < 5; i++) begin
      run_op(t_l[i], t_ac[i], t_op[i][1], t_op[i][2], t_op[i][0], 0,
             lat, strobes, busy, split, l_o, ac_o);
      vectors++;
      if ({l_o, ac_o} !== {e_l[i], e_ac[i]}) begin
        miscompares++;
        $display("FAIL directed%0d_result got=%o/%o want=%o/%o", i, l_o, ac_o, e_l[i], e_ac[i]);
      end
      vectors++;
      if (lat !== e_n[i] + 1 || strobes !== 1 || busy !== e_n[i] + 1 || split !== 0) begin
        miscompares++;
        $display("FAIL directed%0d_timing got lat=%0d strobes=%0d busy=%0d split=%0d want lat=%0d strobes=1 busy=%0d split=0",
                 i, lat, strobes, busy, split, e_n[i] + 1, e_n[i] + 1);
      end
    end
  endtask

  task automatic test_random();
    int lat, strobes, busy, split, n_e;
    logic l_o, l_e, l, ral, rar, bsw;
    logic [11:0] ac_o, ac_e, ac;
    for (int i = 0; i < 40; i++) begin
      l = 1'($urandom); ac = 12'($urandom);
      ral = 1'($urandom); rar = 1'($urandom); bsw = 1'($urandom);
      model(l, ac, ral, rar, bsw, l_e, ac_e, n_e);
      run_op(l, ac, ral, rar, bsw, 0, lat, strobes, busy, split, l_o, ac_o);
      vectors++;
      if ({l_o, ac_o} !== {l_e, ac_e}) begin
        miscompares++;
        $display("FAIL random%0d_result op=%b%b%b in=%o/%o got=%o/%o want=%o/%o",
                 i, rar, ral, bsw, l, ac, l_o, ac_o, l_e, ac_e);
      end
      vectors++;
      if (lat !== n_e + 1 || strobes !== 1 || busy !== n_e + 1 || split !== 0) begin
        miscompares++;
        $display("FAIL random%0d_timing got lat=%0d strobes=%0d busy=%0d split=%0d want lat=%0d strobes=1 busy=%0d",
                 i, lat, strobes, busy, split, n_e + 1, n_e + 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, strobes, busy, split;
    logic l_o;
    logic [11:0] ac_o;
    // restart during the first SHIFT cycle, then during the DONE cycle
    for (int r = 1; r <= 3; r += 2) begin
      run_op(1'b0, 12'o3000, 1'b1, 1'b0, 1'b1, r, lat, strobes, busy, split, l_o, ac_o);
      vectors++;
      if ({l_o, ac_o} !== {1'b1, 12'o4000} || strobes !== 1 || lat !== 3 || busy !== 3) begin
        miscompares++;
        $display("FAIL restart_at%0d got=%o/%o strobes=%0d lat=%0d busy=%0d want=1/4000 strobes=1 lat=3 busy=3",
                 r, l_o, ac_o, strobes, lat, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, strobes, busy, split;
    logic l_o;
    logic [11:0] ac_o;
    run_op(1'b1, 12'o0001, 1'b0, 1'b1, 1'b0, 0, lat, strobes, busy, split, l_o, ac_o);
    run_op(l_o, ac_o, 1'b0, 1'b1, 1'b0, 0, lat, strobes, busy, split, l_o, ac_o);
    vectors++;
    if ({l_o, ac_o} !== {1'b0, 12'o6000}) begin
      miscompares++;
      $display("FAIL back_to_back got=%o/%o want=0/6000", l_o, ac_o);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({bus.LINK_OUT, bus.AC_OUT, bus.BUSY} !== {1'b0, 12'o6000, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_idle got=%o/%o busy=%b want=0/6000 busy=0", bus.LINK_OUT, bus.AC_OUT, bus.BUSY);
    end
  endtask

  task automatic test_reset_mid();
    int lat, strobes, busy, split;
    int seen;
    logic l_o;
    logic [11:0] ac_o;
    @(negedge clk);
    bus.LINK_IN = 1'b0; bus.AC_IN = 12'o3000; bus.RAL = 1; bus.RAR = 0; bus.BSW = 1; bus.START = 1;
    @(negedge clk);
    bus.START = 0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.AC_OUT, bus.LINK_OUT, bus.LINK_SET, bus.AC_LOAD, bus.BUSY} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got=%h want=0000",
               {bus.AC_OUT, bus.LINK_OUT, bus.LINK_SET, bus.AC_LOAD, bus.BUSY});
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.LINK_SET || bus.AC_LOAD || bus.BUSY) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_strobe got=%0d active cycles want=0", seen);
    end
    run_op(1'b0, 12'o0001, 1'b0, 1'b1, 1'b0, 0, lat, strobes, busy, split, l_o, ac_o);
    vectors++;
    if ({l_o, ac_o} !== {1'b1, 12'o0000} || lat !== 2 || strobes !== 1) begin
      miscompares++;
      $display("FAIL after_reset_rar got=%o/%o lat=%0d strobes=%0d want=1/0000 lat=2 strobes=1",
               l_o, ac_o, lat, strobes);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
